pixel_array_ctrl: RTL and testbench
===================================

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 Parameter ERASE_CYCLES, default 5: cycles ERASE is held high.
REQ-002 Parameter EXPOSE_CYCLES, default 255: cycles EXPOSE is held high; legal range 1..65535.
REQ-003 Parameter CONVERT_CYCLES, default 256: conversion length; legal range 1..256.
REQ-004 Parameter READ_CYCLES, default 2: cycles each READ_k is held high; legal range ≥1.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RESET_N  input  1  asynchronous, active-low block reset.
REQ-007 START  input  1  request one full frame (erase, expose, convert, read 4 pixels).
REQ-008 ERASE  output  1  pixel erase strobe to the 4-pixel array.
REQ-009 EXPOSE  output  1  pixel expose strobe.
REQ-010 CONVERT  output  1  high while the conversion counter drives DATA.
REQ-011 READ_1..READ_4  output  1 each  per-pixel read enable.
REQ-012 DATA  inout  8  shared pixel bus; driven by this block only in CONVERT, else high-Z.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 PIXEL_DATA  output  8  captured pixel value.
REQ-015 PIXEL_IDX  output  2  pixel index 0..3 of PIXEL_DATA.
REQ-016 PIXEL_VALID  output  1  PIXEL_DATA/PIXEL_IDX valid.
REQ-017 PIXEL_READY  input  1  downstream accepts when VALID&READY at a rising edge.

Function
REQ-018 States: IDLE, ERASE, EXPOSE, CONVERT, READ, HANDOFF.
REQ-019 IDLE: START=1 at an edge -> ERASE next cycle; START=0 -> stay.
REQ-020 ERASE output high for exactly ERASE_CYCLES cycles, then EXPOSE.
REQ-021 EXPOSE output high for exactly EXPOSE_CYCLES cycles, then CONVERT.
REQ-022 CONVERT: 8-bit counter starts at 0, increments each cycle, DATA = counter; after CONVERT_CYCLES cycles (last value CONVERT_CYCLES-1) -> READ with pixel index 0; counter never wraps.
REQ-023 READ: READ_(idx+1) high for READ_CYCLES cycles; DATA sampled into PIXEL_DATA on the last READ cycle; then HANDOFF.
REQ-024 HANDOFF: PIXEL_VALID=1, PIXEL_DATA/PIXEL_IDX held stable until accepted; all READ_k low.
REQ-025 Acceptance with idx<3 -> READ for idx+1 next cycle; with idx=3 -> IDLE, or directly ERASE if START=1 that same edge.
REQ-026 At most one of ERASE, EXPOSE, CONVERT, READ_1..4 high in any cycle; all strobes registered (glitch-free).
REQ-027 START outside IDLE/final acceptance ignored; no queuing.
REQ-028 PIXEL_READY while PIXEL_VALID=0 has no effect.
REQ-029 DATA high-Z from the cycle after CONVERT ends; no overlap between CONVERT drive and any READ_k.

Reset
REQ-030 RESET_N low asynchronously forces IDLE, all strobes 0, CONVERT=0, DATA high-Z, BUSY=0, PIXEL_VALID=0, PIXEL_DATA=0, PIXEL_IDX=0, counters 0.
REQ-031 Reset mid-frame abandons the frame; first frame after release requires a new START.
REQ-032 Reset deassertion is used synchronously to CLK via the existing two-flop release synchronizer.

Structure
REQ-033 Package pixel_ctrl_pkg holds the state enum and default cycle constants.
REQ-034 One sub-module, phase_counter: loadable down-counter with done flag, reused for all phase durations; conversion counter stays in top level.

Verification
REQ-035 Defaults, START pulse 1 cycle -> ERASE high 5 cycles, EXPOSE 255, CONVERT 256 with DATA 0..255, READ_1..4 each 2 cycles in order.
REQ-036 Bench models pixels returning 8'h11,8'h22,8'h33,8'h44, PIXEL_READY=1 -> PIXEL_DATA sequence 11,22,33,44 with PIXEL_IDX 0..3, then BUSY=0.
REQ-037 PIXEL_READY=0 for 10 cycles at idx 1 -> VALID, DATA=8'h22, IDX=1 held stable; READ_2/READ_3 low throughout.
REQ-038 RESET_N low during CONVERT counter=100 -> same-instant DATA high-Z, all outputs at reset values; START required to restart.
REQ-039 START held high continuously -> back-to-back frames; ERASE asserts the cycle after idx-3 acceptance.
REQ-040 CONVERT_CYCLES=16 -> DATA 0..15 then high-Z; assertion check of one-hot strobes over entire run.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default phase lengths for the 4-pixel array controller.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead,
    StHandoff
  } state_e;

  localparam int unsigned EraseCyclesDef   = 5;
  localparam int unsigned ExposeCyclesDef  = 255;
  localparam int unsigned ConvertCyclesDef = 256;
  localparam int unsigned ReadCyclesDef    = 2;

  // Wide enough for the longest phase (expose, up to 65535 cycles).
  localparam int unsigned PhaseCntW = 16;

  // One-hot read enable for a pixel index (bit 0 = READ_1).
  function automatic logic [3:0] read_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing one controller phase; done marks its last cycle.
module phase_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Reload wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase loaded with N cycles is done while the count reads 1.
  assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 4-pixel array: erase, expose, ramp conversion on DATA,
// then read each pixel and hand it downstream with a valid/ready handshake.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES   = EraseCyclesDef,
  parameter int unsigned EXPOSE_CYCLES  = ExposeCyclesDef,
  parameter int unsigned CONVERT_CYCLES = ConvertCyclesDef,
  parameter int unsigned READ_CYCLES    = ReadCyclesDef
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  output logic       ERASE,
  output logic       EXPOSE,
  output logic       CONVERT,
  output logic       READ_1,
  output logic       READ_2,
  output logic       READ_3,
  output logic       READ_4,
  inout  wire  [7:0] DATA,
  output logic       BUSY,
  output logic [7:0] PIXEL_DATA,
  output logic [1:0] PIXEL_IDX,
  output logic       PIXEL_VALID,
  input  logic       PIXEL_READY
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset asserts immediately but releases two clock edges later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e               state_d, state_q;
  logic [1:0]           idx_d, idx_q;
  logic [7:0]           pdata_d, pdata_q;
  logic [7:0]           conv_cnt_d, conv_cnt_q;
  logic                 erase_d, erase_q;
  logic                 expose_d, expose_q;
  logic                 convert_d, convert_q;
  logic [3:0]           read_d, read_q;
  logic                 valid_d, valid_q;
  logic                 busy_d, busy_q;
  logic                 ph_load;
  logic [PhaseCntW-1:0] ph_load_val;
  logic                 ph_done;

  phase_counter #(
    .Width(PhaseCntW)
  ) u_phase_counter (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .load_i    (ph_load),
    .load_val_i(ph_load_val),
    .done_o    (ph_done)
  );

  // Next state, phase reloads, and strobes decoded from the next state so
  // every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pdata_d     = pdata_q;
    conv_cnt_d  = conv_cnt_q;
    ph_load     = 1'b0;
    ph_load_val = '0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d     = StErase;
          ph_load     = 1'b1;
          ph_load_val = PhaseCntW'(ERASE_CYCLES);
        end
      end
      StErase: begin
        if (ph_done) begin
          state_d     = StExpose;
          ph_load     = 1'b1;
          ph_load_val = PhaseCntW'(EXPOSE_CYCLES);
        end
      end
      StExpose: begin
        if (ph_done) begin
          state_d     = StConvert;
          conv_cnt_d  = 8'd0;
          ph_load     = 1'b1;
          ph_load_val = PhaseCntW'(CONVERT_CYCLES);
        end
      end
      StConvert: begin
        if (ph_done) begin
          // Stop on the last value rather than wrapping past 255.
          state_d     = StRead;
          idx_d       = 2'd0;
          conv_cnt_d  = 8'd0;
          ph_load     = 1'b1;
          ph_load_val = PhaseCntW'(READ_CYCLES);
        end else begin
          conv_cnt_d = conv_cnt_q + 8'd1;
        end
      end
      StRead: begin
        if (ph_done) begin
          pdata_d = DATA;
          state_d = StHandoff;
        end
      end
      StHandoff: begin
        if (PIXEL_READY) begin
          if (idx_q != 2'd3) begin
            state_d     = StRead;
            idx_d       = idx_q + 2'd1;
            ph_load     = 1'b1;
            ph_load_val = PhaseCntW'(READ_CYCLES);
          end else if (START) begin
            state_d     = StErase;
            ph_load     = 1'b1;
            ph_load_val = PhaseCntW'(ERASE_CYCLES);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    erase_d   = (state_d == StErase);
    expose_d  = (state_d == StExpose);
    convert_d = (state_d == StConvert);
    read_d    = (state_d == StRead) ? read_onehot(idx_d) : 4'b0000;
    valid_d   = (state_d == StHandoff);
    busy_d    = (state_d != StIdle);
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      pdata_q    <= 8'd0;
      conv_cnt_q <= 8'd0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      convert_q  <= 1'b0;
      read_q     <= 4'b0000;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pdata_q    <= pdata_d;
      conv_cnt_q <= conv_cnt_d;
      erase_q    <= erase_d;
      expose_q   <= expose_d;
      convert_q  <= convert_d;
      read_q     <= read_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Bus is driven only while CONVERT is high; READ_1 rises on the same edge
  // CONVERT falls, so the drivers never overlap.
  assign DATA = convert_q ? conv_cnt_q : 8'bz;

  assign ERASE       = erase_q;
  assign EXPOSE      = expose_q;
  assign CONVERT     = convert_q;
  assign READ_1      = read_q[0];
  assign READ_2      = read_q[1];
  assign READ_3      = read_q[2];
  assign READ_4      = read_q[3];
  assign BUSY        = busy_q;
  assign PIXEL_DATA  = pdata_q;
  assign PIXEL_IDX   = idx_q;
  assign PIXEL_VALID = valid_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: queue-based frame model checked every cycle,
// table-driven handoff sequence, reset/back-to-back/short-conversion cases.
module tb_pixel_array_ctrl;

  localparam int unsigned EC = 5;
  localparam int unsigned XC = 255;
  localparam int unsigned CC = 256;
  localparam int unsigned RC = 2;

  localparam logic [1:0] K_ERASE  = 2'd0;
  localparam logic [1:0] K_EXPOSE = 2'd1;
  localparam logic [1:0] K_CONV   = 2'd2;
  localparam logic [1:0] K_READ   = 2'd3;

  logic clk;
  logic rst_n_tb;
  logic start;
  logic ready;
  logic [7:0] pix [4];

  int checks;
  int errors;

  // DUT A: default phase lengths.
  logic a_erase, a_expose, a_conv, a_r1, a_r2, a_r3, a_r4, a_busy, a_valid;
  logic [7:0] a_pdata;
  logic [1:0] a_idx;
  wire  [7:0] data_a;
  logic [7:0] drv_a;

  pixel_array_ctrl #(
    .ERASE_CYCLES  (EC),
    .EXPOSE_CYCLES (XC),
    .CONVERT_CYCLES(CC),
    .READ_CYCLES   (RC)
  ) u_dut_a (
    .CLK        (clk),
    .RESET_N    (rst_n_tb),
    .START      (start),
    .ERASE      (a_erase),
    .EXPOSE     (a_expose),
    .CONVERT    (a_conv),
    .READ_1     (a_r1),
    .READ_2     (a_r2),
    .READ_3     (a_r3),
    .READ_4     (a_r4),
    .DATA       (data_a),
    .BUSY       (a_busy),
    .PIXEL_DATA (a_pdata),
    .PIXEL_IDX  (a_idx),
    .PIXEL_VALID(a_valid),
    .PIXEL_READY(ready)
  );

  // Pixel model: selected pixel drives during its read, otherwise a marker
  // value that is visible only when the controller leaves the bus alone.
  always_comb begin
    drv_a = 8'hA5;
    if (a_r1) drv_a = pix[0];
    if (a_r2) drv_a = pix[1];
    if (a_r3) drv_a = pix[2];
    if (a_r4) drv_a = pix[3];
  end
  assign data_a = a_conv ? 8'bz : drv_a;

  // DUT B: short conversion.
  logic b_start, b_ready;
  logic b_erase, b_expose, b_conv, b_r1, b_r2, b_r3, b_r4, b_busy, b_valid;
  logic [7:0] b_pdata;
  logic [1:0] b_idx;
  wire  [7:0] data_b;

  pixel_array_ctrl #(
    .CONVERT_CYCLES(16)
  ) u_dut_b (
    .CLK        (clk),
    .RESET_N    (rst_n_tb),
    .START      (b_start),
    .ERASE      (b_erase),
    .EXPOSE     (b_expose),
    .CONVERT    (b_conv),
    .READ_1     (b_r1),
    .READ_2     (b_r2),
    .READ_3     (b_r3),
    .READ_4     (b_r4),
    .DATA       (data_b),
    .BUSY       (b_busy),
    .PIXEL_DATA (b_pdata),
    .PIXEL_IDX  (b_idx),
    .PIXEL_VALID(b_valid),
    .PIXEL_READY(b_ready)
  );
  assign data_b = b_conv ? 8'bz : 8'hA5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ent_t;
  typedef enum int {MIdle, MSched, MHand} mmode_e;

  ent_t       q[$];
  mmode_e     m_mode;
  logic [1:0] m_idx;
  logic [7:0] m_pdata;
  bit         model_on;

  function automatic void push_n(input logic [1:0] kind, input int n, input bit ramp,
                                 input logic [7:0] v);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.kind = kind;
      e.val  = ramp ? 8'(i) : v;
      q.push_back(e);
    end
  endfunction

  function automatic void push_frame();
    push_n(K_ERASE, EC, 1'b0, 8'd0);
    push_n(K_EXPOSE, XC, 1'b0, 8'd0);
    push_n(K_CONV, CC, 1'b1, 8'd0);
    push_n(K_READ, RC, 1'b0, 8'd0);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_mode  = MIdle;
    m_idx   = 2'd0;
    m_pdata = 8'd0;
  endfunction

  // {BUSY, ERASE, EXPOSE, CONVERT, READ_4..READ_1, PIXEL_VALID}
  function automatic logic [8:0] exp_vec();
    logic [8:0] v;
    v = 9'd0;
    if (m_mode == MHand) begin
      v = 9'b1_000_0000_1;
    end else if (m_mode == MSched) begin
      v[8] = 1'b1;
      case (q[0].kind)
        K_ERASE:  v[7] = 1'b1;
        K_EXPOSE: v[6] = 1'b1;
        K_CONV:   v[5] = 1'b1;
        default:  v[4:1] = 4'b0001 << q[0].val[1:0];
      endcase
    end
    return v;
  endfunction

  // Advance one clock: inputs are stable across the rising edge.
  always @(posedge clk) begin
    if (model_on) begin
      ent_t e;
      case (m_mode)
        MIdle: begin
          if (start) begin
            push_frame();
            m_mode = MSched;
          end
        end
        MSched: begin
          e = q.pop_front();
          if (q.size() == 0) begin
            m_idx   = e.val[1:0];
            m_pdata = pix[e.val[1:0]];
            m_mode  = MHand;
          end
        end
        default: begin
          if (ready) begin
            if (m_idx != 2'd3) begin
              push_n(K_READ, RC, 1'b0, 8'(m_idx + 2'd1));
              m_mode = MSched;
            end else if (start) begin
              push_frame();
              m_mode = MSched;
            end else begin
              m_mode = MIdle;
            end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      logic [8:0] ev;
      ev = exp_vec();
      chk("outputs", {23'd0, a_busy, a_erase, a_expose, a_conv, a_r4, a_r3, a_r2, a_r1, a_valid},
          {23'd0, ev});
      if (m_mode == MSched && q[0].kind == K_CONV) begin
        chk("data_drive", {24'd0, data_a}, {24'd0, q[0].val});
      end else if (ev[4:1] == 4'd0) begin
        chk("data_hiz", {24'd0, data_a}, 32'hA5);
      end
      if (m_mode == MHand) begin
        chk("pixel", {22'd0, a_idx, a_pdata}, {22'd0, m_idx, m_pdata});
      end
    end
  end

  // At most one strobe per cycle on either instance, for the whole run.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0({a_erase, a_expose, a_conv, a_r1, a_r2, a_r3, a_r4}) &&
            $onehot0({b_erase, b_expose, b_conv, b_r1, b_r2, b_r3, b_r4}))
    else begin
      errors++;
      $display("FAIL onehot t=%0t: a=%b b=%b", $time,
               {a_erase, a_expose, a_conv, a_r1, a_r2, a_r3, a_r4},
               {b_erase, b_expose, b_conv, b_r1, b_r2, b_r3, b_r4});
    end
  end

  task automatic check_reset_values(input string name);
    chk({name, "_outs"}, {23'd0, a_busy, a_erase, a_expose, a_conv, a_r4, a_r3, a_r2, a_r1,
        a_valid}, 32'd0);
    chk({name, "_pix"}, {22'd0, a_idx, a_pdata}, 32'd0);
    chk({name, "_hiz"}, {24'd0, data_a}, 32'hA5);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n_tb = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    model_on = 1'b1;
  endtask

  typedef struct {
    int         hold;
    logic [1:0] idx;
    logic [7:0] data;
  } hvec_t;

  hvec_t tbl[4];
  bit    ok;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n_tb = 1'b1;
    start    = 1'b0;
    ready    = 1'b0;
    b_start  = 1'b0;
    b_ready  = 1'b1;
    model_on = 1'b0;
    for (int i = 0; i < 4; i++) pix[i] = 8'd0;
    model_reset();

    tbl[0] = '{hold: 0,  idx: 2'd0, data: 8'h11};
    tbl[1] = '{hold: 10, idx: 2'd1, data: 8'h22};
    tbl[2] = '{hold: 3,  idx: 2'd2, data: 8'h33};
    tbl[3] = '{hold: 0,  idx: 2'd3, data: 8'h44};

    // Power-on reset.
    #3 rst_n_tb = 1'b0;
    #1 check_reset_values("por");
    release_reset();

    // Short conversion: ramp 0..15, then the bus is released.
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (b_conv) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("b_conv_seen", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("b_conv_high", {31'd0, b_conv}, 32'd1);
      chk("b_ramp", {24'd0, data_b}, k);
      @(negedge clk);
    end
    chk("b_conv_end", {31'd0, b_conv}, 32'd0);
    chk("b_read1_next", {28'd0, b_r4, b_r3, b_r2, b_r1}, 32'd1);
    chk("b_bus_free", {24'd0, data_b}, 32'hA5);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!b_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b_done", {31'd0, ok}, 32'd1);

    // Directed frame with fixed pixels and table-driven handoff stalls.
    pix[0] = 8'h11;
    pix[1] = 8'h22;
    pix[2] = 8'h33;
    pix[3] = 8'h44;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        if (a_valid) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("hs_valid_seen", {31'd0, ok}, 32'd1);
      chk("hs_pixel", {22'd0, a_idx, a_pdata}, {22'd0, tbl[i].idx, tbl[i].data});
      for (int h = 0; h < tbl[i].hold; h++) begin
        @(negedge clk);
        chk("hs_stall", {17'd0, a_valid, a_idx, a_pdata, a_r4, a_r3, a_r2, a_r1},
            {17'd0, 1'b1, tbl[i].idx, tbl[i].data, 4'b0000});
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("hs_accepted", {31'd0, a_valid}, 32'd0);
    end
    chk("frame_idle", {31'd0, a_busy}, 32'd0);

    // Reset while the conversion ramp is at 100.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (a_conv && data_a == 8'd100) begin
        ok = 1'b1;
        break;
      end
    end
    chk("conv100_seen", {31'd0, ok}, 32'd1);
    model_on = 1'b0;
    #2 rst_n_tb = 1'b0;
    #1 check_reset_values("midrst");
    release_reset();
    repeat (20) @(negedge clk);
    chk("no_restart", {31'd0, a_busy}, 32'd0);

    // START held high: next frame's ERASE follows the final acceptance.
    start = 1'b1;
    ready = 1'b1;
    ok    = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (a_valid && a_idx == 2'd3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_last_pixel", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("b2b_erase", {30'd0, a_erase, a_busy}, 32'd3);
    start = 1'b0;
    ok    = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!a_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_drain", {31'd0, ok}, 32'd1);

    // Random START/READY traffic with random pixel values.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (m_mode == MIdle) begin
        for (int i = 0; i < 4; i++) pix[i] = 8'($urandom_range(0, 255));
      end
      start = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 2) != 0);
    end
    start = 1'b0;
    ready = 1'b1;
    ok    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!a_busy && m_mode == MIdle) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rand_drain", {31'd0, ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
